// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter (1 start bit, 8 data bits LSB first,
//                STOP_BITS stop bits, CLKS_PER_BIT clocks per bit) fed by a
//                small byte FIFO with a valid/ready push interface.
//                Define UART_TX_PARITY_EN to insert an even-parity bit
//                between the data bits and the stop bit(s).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_TW = $clog2(CLKS_PER_BIT * STOP_BITS) + 1;

    localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_STOP_LAST = c_TW'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);
    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [c_TW-1:0]   r_tick, w_tick_nxt;
    logic [2:0]        r_bit_cnt, w_bit_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_tx, w_tx_nxt;
    logic              w_push, w_pop;
    logic              w_nonempty;
    logic [7:0]        w_head;
`ifdef UART_TX_PARITY_EN
    logic              r_parity, w_parity_nxt;
`endif

    assign in_ready   = (r_count != c_FULL);
    assign w_push     = in_valid && in_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;

    // FIFO storage: written at the write pointer on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmitter state register; tx line is registered and idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // Next-state logic: bit timing, shifting, and popping the next queued byte
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick + c_TICK_ONE;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_tx_nxt     = r_tx;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^w_head;
`endif
                    w_tx_nxt    = 1'b0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_nxt  = '0;
                    w_tx_nxt    = r_shift[0];
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_nxt = '0;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = r_parity;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_nxt  = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_tick == c_STOP_LAST) begin
                    w_tick_nxt = '0;
                    if (w_nonempty) begin
                        // back-to-back: next start bit follows the stop bit directly
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                        w_parity_nxt = ^w_head;
`endif
                        w_tx_nxt    = 1'b0;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_tick_nxt  = '0;
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
